// File: rtl/apb_regbank_pkg.sv
// apb_regbank_pkg: shared types, constants and the byte-strobe expansion helper for the APB register bank.
`default_nettype none

package apb_regbank_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // Expands up to 8 byte enables into a 64-bit bit mask; callers keep the low DATA_WIDTH bits.
   function automatic logic [63:0] strb_mask(input logic [7:0] strb);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < 8; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regbank_if.sv
// apb_regbank_if: APB4 bus bundle (address/control/data/response) with master and slave views.
`default_nettype none

interface apb_regbank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic                    PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

`default_nettype wire

// File: rtl/apb_regbank_slave_wait_counter.sv
// apb_wait_counter: loadable down-counter whose zero flag gates PREADY in the ACCESS phase.
`default_nettype none

module apb_wait_counter
   import apb_regbank_pkg::*;
(
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  load_i,
   input  wire logic [WAIT_CNT_W-1:0] load_val_i,
   input  wire logic                  dec_i,
   output logic                       zero_o
);
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 register bank with wait states and byte strobes.
// Define APB_SLVERR_EN to report out-of-range accesses and strobed reads through PSLVERR.
`default_nettype none

module apb_regbank_slave
   import apb_regbank_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  wire logic     PCLK,
   input  wire logic     PRESETn,
   apb_regbank_if.slave  bus
);
   localparam int BL    = $clog2(DATA_WIDTH/8);
   localparam int IDX_W = ADDR_WIDTH - BL;
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_e                state_q, state_d;
   logic                  w_load, w_zero, w_access, w_ready;
   logic                  w_in_range, w_err, w_done, w_wr_en;
   logic [IDX_W-1:0]      w_idx;
   logic [SEL_W-1:0]      w_sel;
   logic [63:0]           w_mask_full;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   assign w_idx       = bus.PADDR[ADDR_WIDTH-1:BL];
   assign w_sel       = w_idx[SEL_W-1:0];
   assign w_in_range  = (32'(w_idx) < 32'(NUM_REGS));
   assign w_mask_full = strb_mask(8'(bus.PSTRB));
   assign w_mask      = w_mask_full[DATA_WIDTH-1:0];

   generate
      if (DATA_WIDTH < 64) begin : g_mask_hi
         logic unused_mask_hi;
         assign unused_mask_hi = ^w_mask_full[63:DATA_WIDTH];
      end
      if (BL > 0) begin : g_addr_lo
         logic unused_addr_lo;
         assign unused_addr_lo = ^bus.PADDR[BL-1:0];
      end
   endgenerate

   apb_wait_counter u_wait (
      .clk        (PCLK),
      .rst_n      (PRESETn),
      .load_i     (w_load),
      .load_val_i (WAIT_CNT_W'(WAIT_CYCLES)),
      .dec_i      (w_access),
      .zero_o     (w_zero)
   );

   // A fresh setup while in ACCESS restarts the wait period for the new transfer.
   always_comb begin
      state_d = state_q;
      w_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.PSEL && !bus.PENABLE) begin
               state_d = ACCESS;
               w_load  = 1'b1;
            end
         end
         ACCESS: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
            end else if (!bus.PENABLE) begin
               w_load = 1'b1;
            end else if (w_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign w_access = (state_q == ACCESS);
   assign w_ready  = w_access && w_zero;
   assign w_done   = w_ready && bus.PSEL && bus.PENABLE;

`ifdef APB_SLVERR_EN
   assign w_err = !w_in_range || (!bus.PWRITE && (bus.PSTRB != '0));
`else
   assign w_err = 1'b0;
`endif

   assign w_wr_en = w_done && bus.PWRITE && w_in_range && !w_err;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_en && (w_sel == SEL_W'(i))) begin
               regs_q[i] <= (regs_q[i] & ~w_mask) | (bus.PWDATA & w_mask);
            end
         end
      end
   end

   assign bus.PREADY  = w_ready;
   assign bus.PSLVERR = w_ready && w_err;
   assign bus.PRDATA  = (w_access && !bus.PWRITE && w_in_range) ? regs_q[w_sel] : '0;

endmodule

`default_nettype wire
